// File: rtl/mmm_pkg.sv
// Shared front-end definitions: architectural widths and the instruction-queue entry type.
package mmm_pkg;

   localparam int XLEN     = 32;
   localparam int ILEN     = 32;
   localparam int IQ_DEPTH = 4;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Decoupling FIFO between fetch and decode: holds {instr, pc} entries, cleared by flush_i.
// Optional zero-latency empty-queue bypass when IQ_BYPASS_EN is defined.
module instr_queue
   import mmm_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     flush_i,
   input  logic                     fetch_valid_i,
   output logic                     fetch_ready_o,
   input  logic [ILEN-1:0]          instr_i,
   input  logic [XLEN-1:0]          pc_i,
   output logic                     issue_valid_o,
   input  logic                     issue_ready_i,
   output logic [ILEN-1:0]          instr_o,
   output logic [XLEN-1:0]          pc_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("instr_queue: DEPTH must be a power of two and >= 2");
   end

   iq_entry_t           mem [DEPTH];
   logic [PW-1:0]       head_q;
   logic [PW-1:0]       tail_q;
   logic [CW-1:0]       count_q;
   logic                not_empty;
   logic                do_push;
   logic                do_pop;
   iq_entry_t           head_entry;

   assign not_empty     = (count_q != '0);
   assign head_entry    = mem[head_q];
   assign fetch_ready_o = (count_q < CW'(DEPTH)) & ~flush_i;

`ifdef IQ_BYPASS_EN
   logic bypass;

   // An empty queue forwards the fetch entry straight to decode; it is only
   // stored if decode does not take it this cycle.
   assign bypass        = ~not_empty & fetch_valid_i & ~flush_i;
   assign issue_valid_o = (not_empty | bypass) & ~flush_i;
   assign instr_o       = bypass ? instr_i : head_entry.instr;
   assign pc_o          = bypass ? pc_i    : head_entry.pc;
   assign do_push       = fetch_valid_i & fetch_ready_o & ~(bypass & issue_ready_i);
   assign do_pop        = issue_valid_o & issue_ready_i & not_empty;
`else
   assign issue_valid_o = not_empty & ~flush_i;
   assign instr_o       = head_entry.instr;
   assign pc_o          = head_entry.pc;
   assign do_push       = fetch_valid_i & fetch_ready_o;
   assign do_pop        = issue_valid_o & issue_ready_i;
`endif

   assign count_o = count_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= tail_q + 1'b1;
         if (do_pop)  head_q <= head_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is intentionally not reset; do_push is already gated off by flush_i.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[tail_q].instr <= instr_i;
         mem[tail_q].pc    <= pc_i;
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue at DEPTH=4.
module tb_instr_queue;
   import mmm_pkg::*;

   localparam int DEPTH = 4;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic             flush_i;
   logic             fetch_valid_i;
   logic             fetch_ready_o;
   logic [ILEN-1:0]  instr_i;
   logic [XLEN-1:0]  pc_i;
   logic             issue_valid_o;
   logic             issue_ready_i;
   logic [ILEN-1:0]  instr_o;
   logic [XLEN-1:0]  pc_o;
   logic [2:0]       count_o;

   int vectors = 0;
   int errors  = 0;

   instr_queue #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
      .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
      .instr_i(instr_i), .pc_i(pc_i),
      .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
      .instr_o(instr_o), .pc_o(pc_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   // Pointer/occupancy invariant.
   always @(negedge clk_i) begin
      logic [1:0] diff;
      if (rst_n_i) begin
         diff = dut.tail_q - dut.head_q;
         vectors++;
         if (!((diff != 2'd0 && count_o == {1'b0, diff}) ||
               (diff == 2'd0 && (count_o == 3'd0 || count_o == 3'd4)))) begin
            errors++;
            $display("FAIL invariant: count_o=%0d tail-head=%0d", count_o, diff);
         end
      end
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b1;
      instr_i = 32'hdead_beef; pc_i = 32'h44; issue_ready_i = 1'b0;
      cyc(); cyc();
      vectors++;
      if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
      vectors++;
      if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", issue_valid_o); end
      fetch_valid_i = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      vectors++;
      if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", fetch_ready_o); end
      cyc();
   endtask

   task automatic test_single_push();
      fetch_valid_i = 1'b1; instr_i = 32'h0000_0013; pc_i = 32'h0; issue_ready_i = 1'b1;
      #1;
      vectors++;
      if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL single_latency: valid got %b want 0", issue_valid_o); end
      cyc();
      fetch_valid_i = 1'b0;
      #1;
      vectors++;
      if (issue_valid_o !== 1'b1 || instr_o !== 32'h13 || pc_o !== 32'h0 || count_o !== 3'd1) begin
         errors++;
         $display("FAIL single_out: valid=%b instr=%h pc=%h count=%0d want 1/00000013/0/1",
                  issue_valid_o, instr_o, pc_o, count_o);
      end
      cyc();
      vectors++;
      if (count_o !== 3'd0 || issue_valid_o !== 1'b0) begin
         errors++; $display("FAIL single_pop: count=%0d valid=%b want 0/0", count_o, issue_valid_o);
      end
   endtask

   task automatic test_back_to_back();
      logic accepted;
      issue_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fetch_valid_i = 1'b1; pc_i = 32'(4 * i); instr_i = 32'h100 + 32'(i);
         #1;
         vectors++;
         if (fetch_ready_o !== (i < 4)) begin
            errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, fetch_ready_o, (i < 4));
         end
         if (i < 4) cyc();
      end
      vectors++;
      if (count_o !== 3'd4) begin errors++; $display("FAIL b2b_full_count: got %0d want 4", count_o); end
      issue_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         vectors++;
         if (issue_valid_o !== 1'b1 || pc_o !== 32'(4 * k) || instr_o !== 32'h100 + 32'(k)) begin
            errors++;
            $display("FAIL b2b_order[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h",
                     k, issue_valid_o, pc_o, instr_o, 32'(4 * k), 32'h100 + 32'(k));
         end
         if (k == 0) begin
            vectors++;
            if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full_pop_ready: got %b want 0", fetch_ready_o); end
         end
         accepted = fetch_valid_i & fetch_ready_o;
         cyc();
         if (accepted) fetch_valid_i = 1'b0;
      end
      vectors++;
      if (count_o !== 3'd0 || issue_valid_o !== 1'b0) begin
         errors++; $display("FAIL b2b_drain: count=%0d valid=%b want 0/0", count_o, issue_valid_o);
      end
   endtask

   task automatic test_push_pop_steady();
      issue_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         fetch_valid_i = 1'b1; pc_i = 32'h200 + 32'(4 * i); instr_i = 32'h2000 + 32'(i);
         cyc();
      end
      issue_ready_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         pc_i = 32'h208 + 32'(4 * k); instr_i = 32'h2002 + 32'(k);
         #1;
         vectors++;
         if (count_o !== 3'd2 || pc_o !== 32'h200 + 32'(4 * k) || instr_o !== 32'h2000 + 32'(k)) begin
            errors++;
            $display("FAIL steady[%0d]: count=%0d pc=%h instr=%h want 2/%h/%h",
                     k, count_o, pc_o, instr_o, 32'h200 + 32'(4 * k), 32'h2000 + 32'(k));
         end
         cyc();
      end
      fetch_valid_i = 1'b0;
      for (int k = 10; k < 12; k++) begin
         vectors++;
         if (pc_o !== 32'h200 + 32'(4 * k)) begin
            errors++; $display("FAIL steady_drain[%0d]: pc=%h want %h", k, pc_o, 32'h200 + 32'(4 * k));
         end
         cyc();
      end
      vectors++;
      if (count_o !== 3'd0) begin errors++; $display("FAIL steady_empty: got %0d want 0", count_o); end
   endtask

   task automatic test_flush();
      issue_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fetch_valid_i = 1'b1; pc_i = 32'h300 + 32'(4 * i); instr_i = 32'h3000 + 32'(i);
         cyc();
      end
      vectors++;
      if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count_o); end
      flush_i = 1'b1; fetch_valid_i = 1'b1; pc_i = 32'h3ff; issue_ready_i = 1'b1;
      #1;
      vectors++;
      if (issue_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
         errors++; $display("FAIL flush_mask: valid=%b ready=%b want 0/0", issue_valid_o, fetch_ready_o);
      end
      cyc();
      flush_i = 1'b0; fetch_valid_i = 1'b0;
      #1;
      vectors++;
      if (count_o !== 3'd0 || issue_valid_o !== 1'b0) begin
         errors++; $display("FAIL flush_clear: count=%0d valid=%b want 0/0", count_o, issue_valid_o);
      end
      for (int k = 0; k < 3; k++) begin
         cyc();
         vectors++;
         if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL flush_quiet[%0d]: valid=%b want 0", k, issue_valid_o); end
      end
      fetch_valid_i = 1'b1; pc_i = 32'h400; instr_i = 32'h4000;
      cyc();
      fetch_valid_i = 1'b0;
      #1;
      vectors++;
      if (issue_valid_o !== 1'b1 || pc_o !== 32'h400 || instr_o !== 32'h4000) begin
         errors++; $display("FAIL flush_repush: valid=%b pc=%h instr=%h want 1/400/4000", issue_valid_o, pc_o, instr_o);
      end
      cyc();
   endtask

   task automatic test_async_reset();
      issue_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         fetch_valid_i = 1'b1; pc_i = 32'h500 + 32'(4 * i); instr_i = 32'h5000;
         cyc();
      end
      vectors++;
      if (count_o !== 3'd2) begin errors++; $display("FAIL areset_pre: count=%0d want 2", count_o); end
      #1;
      rst_n_i = 1'b0;
      #1;
      vectors++;
      if (count_o !== 3'd0 || issue_valid_o !== 1'b0) begin
         errors++; $display("FAIL areset_now: count=%0d valid=%b want 0/0", count_o, issue_valid_o);
      end
      fetch_valid_i = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      cyc();
   endtask

`ifdef IQ_BYPASS_EN
   task automatic test_bypass();
      fetch_valid_i = 1'b1; pc_i = 32'h100; instr_i = 32'h600; issue_ready_i = 1'b1;
      #1;
      vectors++;
      if (issue_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'h600) begin
         errors++; $display("FAIL bypass_same_cycle: valid=%b pc=%h want 1/100", issue_valid_o, pc_o);
      end
      cyc();
      fetch_valid_i = 1'b0;
      #1;
      vectors++;
      if (count_o !== 3'd0) begin errors++; $display("FAIL bypass_consumed: count=%0d want 0", count_o); end
      fetch_valid_i = 1'b1; issue_ready_i = 1'b0;
      cyc();
      fetch_valid_i = 1'b0;
      vectors++;
      if (count_o !== 3'd1 || pc_o !== 32'h100) begin
         errors++; $display("FAIL bypass_stored: count=%0d pc=%h want 1/100", count_o, pc_o);
      end
      issue_ready_i = 1'b1;
      cyc();
      issue_ready_i = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
`ifdef IQ_BYPASS_EN
      test_bypass();
`else
      test_single_push();
`endif
      test_back_to_back();
      test_push_pop_steady();
      test_flush();
      test_async_reset();
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
